// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and enums for the fetch sequencer
package core_pkg;
    localparam int PC_W = 8;
    localparam logic [7:0] HALT_OP     = 8'b10001000;
    localparam logic [7:0] PROG0_START = 8'd0;
    localparam logic [7:0] PROG1_START = 8'd93;
    localparam logic [7:0] PROG2_START = 8'd139;

    typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;

    typedef enum logic [2:0] {PC_HOLD, PC_INC, PC_FWD, PC_BWD, PC_ENTRY} pc_sel_e;
endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC selection
module pc_next
    import core_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  pc_sel_e          sel_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  issue_pc_i,
    input  logic [PC_W-1:0]  off_i,
    input  logic [PC_W-1:0]  entry_i,
    output logic [PC_W-1:0]  next_pc_o
);
    // Branch targets are relative to the instruction after the branch; wrap is silent.
    always_comb begin
        next_pc_o = pc_i;
        case (sel_i)
            PC_INC:   next_pc_o = pc_i + PC_W'(1);
            PC_FWD:   next_pc_o = issue_pc_i + PC_W'(1) + off_i;
            PC_BWD:   next_pc_o = issue_pc_i + PC_W'(1) - off_i;
            PC_ENTRY: next_pc_o = entry_i;
            default:  next_pc_o = pc_i;
        endcase
    end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, issue slot and run control for the ROM fetch
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int              PC_W        = core_pkg::PC_W,
    parameter logic [PC_W-1:0] PROG0_START = core_pkg::PROG0_START,
    parameter logic [PC_W-1:0] PROG1_START = core_pkg::PROG1_START,
    parameter logic [PC_W-1:0] PROG2_START = core_pkg::PROG2_START,
    parameter logic [7:0]      HALT_OP     = core_pkg::HALT_OP,
    parameter int              CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       prog_sel_i,
    input  logic             stall_i,
    input  logic             br_fwd_i,
    input  logic             br_bwd_i,
    input  logic             br_taken_i,
    input  logic [PC_W-1:0]  br_off_i,
    output logic [PC_W-1:0]  inst_addr_o,
    input  logic [7:0]       inst_data_i,
    output logic [7:0]       inst_o,
    output logic [PC_W-1:0]  issue_pc_o,
    output logic             inst_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic             err_o
);
    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, issue_pc_q, issue_pc_d, entry;
    logic [7:0]       inst_q, inst_d;
    logic             valid_q, valid_d, err_q, err_d, busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pc_sel_e          pc_sel;

    always_comb begin
        case (prog_sel_i)
            2'd0:    entry = PROG0_START;
            2'd1:    entry = PROG1_START;
            default: entry = PROG2_START;
        endcase
    end

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .sel_i      (pc_sel),
        .pc_i       (pc_q),
        .issue_pc_i (issue_pc_q),
        .off_i      (br_off_i),
        .entry_i    (entry),
        .next_pc_o  (pc_d)
    );

    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        issue_pc_d = issue_pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pc_sel     = PC_HOLD;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (prog_sel_i != 2'd3) begin
                        pc_sel  = PC_ENTRY;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!stall_i) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    if (valid_q && inst_q == HALT_OP) begin
                        valid_d = 1'b0;
                        state_d = HALT;
                    end else begin
                        if (valid_q && br_fwd_i && br_bwd_i) begin
                            err_d = 1'b1;
                        end
                        // A taken branch redirects the PC and squashes the fetch in flight.
                        if (valid_q && br_taken_i && (br_fwd_i ^ br_bwd_i)) begin
                            pc_sel  = br_fwd_i ? PC_FWD : PC_BWD;
                            valid_d = 1'b0;
                        end else begin
                            inst_d     = inst_data_i;
                            issue_pc_d = pc_q;
                            valid_d    = 1'b1;
                            pc_sel     = PC_INC;
                        end
                    end
                end
            end
            HALT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == HALT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            inst_q     <= '0;
            issue_pc_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            issue_pc_q <= issue_pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign issue_pc_o   = issue_pc_q;
    assign inst_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cycle_cnt_o  = cnt_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_ni, start_i, stall_i, br_fwd_i, br_bwd_i, br_taken_i;
    logic [1:0]  prog_sel_i;
    logic [7:0]  br_off_i, inst_addr_o, inst_data_i, inst_o, issue_pc_o;
    logic        inst_valid_o, busy_o, done_o, err_o;
    logic [15:0] cycle_cnt_o, cnt_snap;

    logic [7:0]  rom [256];
    logic [7:0]  sb_q [$];
    int          vectors = 0;
    int          errs = 0;
    int          run_ticks = 0;
    bit          count_en = 1'b0;

    fetch_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .prog_sel_i   (prog_sel_i),
        .stall_i      (stall_i),
        .br_fwd_i     (br_fwd_i),
        .br_bwd_i     (br_bwd_i),
        .br_taken_i   (br_taken_i),
        .br_off_i     (br_off_i),
        .inst_addr_o  (inst_addr_o),
        .inst_data_i  (inst_data_i),
        .inst_o       (inst_o),
        .issue_pc_o   (issue_pc_o),
        .inst_valid_o (inst_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cycle_cnt_o  (cycle_cnt_o),
        .err_o        (err_o)
    );

    assign inst_data_i = rom[inst_addr_o];

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (count_en && !stall_i) run_ticks++;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic clear_br();
        br_fwd_i = 1'b0; br_bwd_i = 1'b0; br_taken_i = 1'b0; br_off_i = 8'd0;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) sb_q.push_back(8'(a));
    endtask

    task automatic expect_issue();
        logic [7:0] p;
        if (sb_q.size() == 0) begin
            vectors++;
            errs++;
            $error("FAIL sb_underflow: observed issue_pc %0h, expected no issue", issue_pc_o);
        end else begin
            p = sb_q.pop_front();
            check("issue_valid", inst_valid_o, 1'b1);
            check("issue_pc", issue_pc_o, p);
            check("issue_inst", inst_o, rom[p]);
        end
    endtask

    task automatic run_issues(input int n);
        repeat (n) begin
            tick();
            expect_issue();
        end
    endtask

    task automatic start_prog(input logic [1:0] sel);
        prog_sel_i = sel;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, inst_addr_o, 8'd0);
        check({tag, "_inst"}, inst_o, 8'd0);
        check({tag, "_ipc"}, issue_pc_o, 8'd0);
        check({tag, "_valid"}, inst_valid_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_cnt"}, cycle_cnt_o, 16'd0);
        check({tag, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'(i * 37 + 5);
            if (rom[i] == 8'h88) rom[i] = 8'h00;
        end
        rom[0] = 8'hC1; rom[24] = 8'hC0; rom[92] = 8'h88; rom[139] = 8'hD0;

        rst_ni = 1'b0; start_i = 1'b0; stall_i = 1'b0; prog_sel_i = 2'd0;
        clear_br();
        @(negedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;
        tick();

        start_prog(2'd3);
        check("illegal_err", err_o, 1'b1);
        check("illegal_busy", busy_o, 1'b0);
        tick();
        check("illegal_idle", busy_o, 1'b0);

        start_prog(2'd0);
        count_en = 1'b1;
        check("p0_addr", inst_addr_o, 8'd0);
        check("p0_busy", busy_o, 1'b1);
        check("p0_err_clr", err_o, 1'b0);
        check("p0_valid0", inst_valid_o, 1'b0);
        check("p0_cnt0", cycle_cnt_o, 16'd0);
        push_range(0, 17);
        tick();
        expect_issue();
        check("p0_first_inst", inst_o, 8'hC1);
        run_issues(17);

        br_fwd_i = 1'b1; br_taken_i = 1'b1; br_off_i = 8'd6;
        tick();
        clear_br();
        check("fwd_bubble", inst_valid_o, 1'b0);
        check("fwd_target", inst_addr_o, 8'd24);
        sb_q.push_back(8'd24);
        tick();
        expect_issue();
        check("fwd_inst", inst_o, 8'hC0);

        br_fwd_i = 1'b1; br_off_i = 8'd6;
        sb_q.push_back(8'd25);
        tick();
        clear_br();
        expect_issue();

        br_fwd_i = 1'b1; br_bwd_i = 1'b1; br_taken_i = 1'b1; br_off_i = 8'd6;
        sb_q.push_back(8'd26);
        tick();
        clear_br();
        expect_issue();
        check("both_err", err_o, 1'b1);

        push_range(27, 47);
        run_issues(21);

        cnt_snap = cycle_cnt_o;
        stall_i = 1'b1;
        br_bwd_i = 1'b1; br_taken_i = 1'b1; br_off_i = 8'd36;
        repeat (3) begin
            tick();
            check("stall_ipc", issue_pc_o, 8'd47);
            check("stall_valid", inst_valid_o, 1'b1);
            check("stall_addr", inst_addr_o, 8'd48);
            check("stall_cnt", cycle_cnt_o, cnt_snap);
        end
        stall_i = 1'b0;
        tick();
        clear_br();
        check("bwd_bubble", inst_valid_o, 1'b0);
        check("bwd_target", inst_addr_o, 8'd12);
        sb_q.push_back(8'd12);
        tick();
        expect_issue();

        push_range(13, 92);
        run_issues(80);
        check("halt_inst", inst_o, 8'h88);
        tick();
        count_en = 1'b0;
        check("halt_done", done_o, 1'b1);
        check("halt_busy", busy_o, 1'b0);
        check("halt_valid", inst_valid_o, 1'b0);
        check("halt_cnt", cycle_cnt_o, 16'(run_ticks));
        tick();
        check("idle_done", done_o, 1'b0);
        check("idle_busy", busy_o, 1'b0);
        check("idle_cnt", cycle_cnt_o, 16'(run_ticks));
        check("idle_ipc", issue_pc_o, 8'd92);

        start_prog(2'd2);
        check("p2_addr", inst_addr_o, 8'd139);
        check("p2_err_clr", err_o, 1'b0);
        check("p2_cnt0", cycle_cnt_o, 16'd0);
        sb_q.push_back(8'd139);
        tick();
        expect_issue();
        check("p2_first_inst", inst_o, 8'hD0);
        sb_q.push_back(8'd140);
        tick();
        expect_issue();

        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        start_prog(2'd0);
        push_range(0, 2);
        run_issues(3);
        br_bwd_i = 1'b1; br_taken_i = 1'b1; br_off_i = 8'd10;
        tick();
        clear_br();
        check("wrap_bubble", inst_valid_o, 1'b0);
        check("wrap_target", inst_addr_o, 8'd249);
        sb_q.push_back(8'd249);
        tick();
        expect_issue();
        check("wrap_err", err_o, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
